// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit single-cycle processor: opcodes, ALU
// operation codes and the decoded control bundle.
package proc_pkg;

   localparam logic [2:0] OP_RTYPE = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_ADDI  = 3'b010;
   localparam logic [2:0] OP_LW    = 3'b011;
   localparam logic [2:0] OP_SW    = 3'b100;
   localparam logic [2:0] OP_BEQ   = 3'b101;
   localparam logic [2:0] OP_LI    = 3'b110;
   localparam logic [2:0] OP_J     = 3'b111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
      logic       li;
      logic       m;
      logic [1:0] alu_ctrl;
   } ctrl_t;

endpackage

// File: rtl/exec_ctrl_mem_unit_alu.sv
// Combinational 2-bit-op ALU with zero flag; results wrap modulo 2**DATA_W.
module exec_alu8
   import proc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [1:0]        ctrl,
   output logic [DATA_W-1:0] y,
   output logic              zero
);

   always_comb begin
      y = '0;
      case (ctrl)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         default: y = '0;
      endcase
      zero = (y == '0);
   end

endmodule

// File: rtl/exec_ctrl_mem_unit.sv
// Execute/memory core: instruction decode, operand and writeback muxes,
// the ALU and a reset-clearable data memory with asynchronous read.
module exec_ctrl_mem_unit
   import proc_pkg::*;
#(
   parameter int DM_ADDR_W = 8,
   parameter int DATA_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        instr,
   input  logic [DATA_W-1:0] rd_data1,
   input  logic [DATA_W-1:0] rd_data2,
   output logic              reg_write,
   output logic              reg_waddr,
   output logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] alu_out,
   output logic              zero,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              branch_taken,
   output logic              jump,
   output logic              li
);

   localparam int DM_DEPTH = 2 ** DM_ADDR_W;

   logic [2:0]           op;
   logic                 rs;
   logic                 rt;
   logic [2:0]           imm3;
   logic [3:0]           imm4;
   logic [1:0]           fn;
   ctrl_t                ctrl;
   logic signed [DATA_W-1:0] sext;
   logic [DATA_W-1:0]    zext;
   logic [DATA_W-1:0]    ext;
   logic [DATA_W-1:0]    alu_a;
   logic [DATA_W-1:0]    alu_b;
   logic [DM_ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0]    mem_q [DM_DEPTH];
   logic [DATA_W-1:0]    mem_d [DM_DEPTH];

   assign op   = instr[7:5];
   assign rs   = instr[4];
   assign rt   = instr[3];
   assign imm3 = instr[2:0];
   assign imm4 = instr[3:0];
   assign fn   = instr[1:0];

   always_comb begin
      ctrl = '0;
      case (op)
         OP_RTYPE: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_ctrl  = fn;
         end
         OP_SUB: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_ctrl  = ALU_SUB;
         end
         OP_ADDI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_ctrl  = ALU_ADD;
         end
         OP_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_ctrl   = ALU_ADD;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.alu_ctrl  = ALU_ADD;
         end
         OP_BEQ: begin
            ctrl.branch   = 1'b1;
            ctrl.alu_ctrl = ALU_SUB;
         end
         OP_LI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.li        = 1'b1;
            ctrl.m         = 1'b1;
            ctrl.alu_ctrl  = ALU_ADD;
         end
         OP_J: begin
            ctrl.jump = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   // LI uses the unsigned 4-bit immediate with a zero A operand; all other
   // immediates are signed 3-bit offsets.
   assign sext  = {{(DATA_W-3){imm3[2]}}, imm3};
   assign zext  = {{(DATA_W-4){1'b0}}, imm4};
   assign ext   = ctrl.m ? zext : sext;
   assign alu_a = ctrl.li ? '0 : rd_data1;
   assign alu_b = ctrl.alu_src ? ext : rd_data2;

   exec_alu8 #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a    (alu_a),
      .b    (alu_b),
      .ctrl (ctrl.alu_ctrl),
      .y    (alu_out),
      .zero (zero)
   );

   assign dm_addr   = alu_out[DM_ADDR_W-1:0];
   assign mem_rdata = ctrl.mem_read ? mem_q[dm_addr] : '0;

   // Reads see mem_q, so a same-address write only shows up after the edge.
   always_comb begin
      mem_d = mem_q;
      if (ctrl.mem_write) begin
         mem_d[dm_addr] = rd_data2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign reg_write    = ctrl.reg_write & ~rst;
   assign reg_waddr    = ctrl.m ? rs : rt;
   assign wb_data      = ctrl.mem_to_reg ? mem_rdata : alu_out;
   assign branch_taken = ctrl.branch & zero;
   assign jump         = ctrl.jump;
   assign li           = ctrl.li;

endmodule

// File: tb/tb_exec_ctrl_mem_unit.sv
// Scenario bench for exec_ctrl_mem_unit: expectations queued on drive,
// popped and compared once the combinational outputs settle.
module tb_exec_ctrl_mem_unit;

   typedef struct {
      logic [7:0] alu;
      logic       z;
      logic [7:0] wb;
      logic [7:0] mrd;
      logic       rw;
      logic       wa;
      logic       bt;
      logic       j;
      logic       li;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] instr;
   logic [7:0] rd_data1;
   logic [7:0] rd_data2;
   logic       reg_write;
   logic       reg_waddr;
   logic [7:0] wb_data;
   logic [7:0] alu_out;
   logic       zero;
   logic [7:0] mem_rdata;
   logic       branch_taken;
   logic       jump;
   logic       li;

   exp_t sb[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   exec_ctrl_mem_unit #(
      .DM_ADDR_W (8),
      .DATA_W    (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .rd_data1     (rd_data1),
      .rd_data2     (rd_data2),
      .reg_write    (reg_write),
      .reg_waddr    (reg_waddr),
      .wb_data      (wb_data),
      .alu_out      (alu_out),
      .zero         (zero),
      .mem_rdata    (mem_rdata),
      .branch_taken (branch_taken),
      .jump         (jump),
      .li           (li)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [7:0] alu, input logic z, input logic [7:0] wb,
                               input logic [7:0] mrd, input logic rw, input logic wa,
                               input logic bt, input logic j, input logic l);
      exp_t r;
      r.alu = alu; r.z = z; r.wb = wb; r.mrd = mrd; r.rw = rw;
      r.wa = wa; r.bt = bt; r.j = j; r.li = l;
      return r;
   endfunction

   task automatic apply(input logic r, input logic [7:0] i, input logic [7:0] a,
                        input logic [7:0] b, input exp_t ex);
      rst      = r;
      instr    = i;
      rd_data1 = a;
      rd_data2 = b;
      sb.push_back(ex);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      apply(1'b1, 8'h68, 8'h12, 8'h00, mk(8'h12, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      checks++;
      if (reg_write !== e.rw) begin
         errors++; $display("FAIL rst_reg_write: got %0b want %0b", reg_write, e.rw);
      end
      @(negedge clk);
      apply(1'b0, 8'h68, 8'h12, 8'h00, mk(8'h12, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      checks++;
      if (mem_rdata !== e.mrd) begin
         errors++; $display("FAIL rst_mem_rdata: got %h want %h", mem_rdata, e.mrd);
      end
      checks++;
      if (wb_data !== e.wb) begin
         errors++; $display("FAIL rst_wb_data: got %h want %h", wb_data, e.wb);
      end
      checks++;
      if (reg_write !== e.rw) begin
         errors++; $display("FAIL rst_lw_reg_write: got %0b want %0b", reg_write, e.rw);
      end
   endtask

   task automatic test_li();
      @(negedge clk);
      apply(1'b0, 8'hD5, 8'hAA, 8'h55, mk(8'h05, 1'b0, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
      e = sb.pop_front();
      checks++;
      if (li !== e.li) begin errors++; $display("FAIL li_flag: got %0b want %0b", li, e.li); end
      checks++;
      if (alu_out !== e.alu) begin errors++; $display("FAIL li_alu: got %h want %h", alu_out, e.alu); end
      checks++;
      if (reg_waddr !== e.wa) begin errors++; $display("FAIL li_waddr: got %0b want %0b", reg_waddr, e.wa); end
      checks++;
      if (wb_data !== e.wb) begin errors++; $display("FAIL li_wb: got %h want %h", wb_data, e.wb); end
      checks++;
      if (reg_write !== e.rw) begin errors++; $display("FAIL li_rw: got %0b want %0b", reg_write, e.rw); end
   endtask

   task automatic test_alu_ops();
      logic [7:0] ins [6] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h28, 8'h4F};
      logic [7:0] a   [6] = '{8'hF0, 8'h33, 8'hF0, 8'hF0, 8'h10, 8'h05};
      logic [7:0] b   [6] = '{8'h20, 8'h33, 8'h3C, 8'h3C, 8'h30, 8'hEE};
      logic [7:0] res [6] = '{8'h10, 8'h00, 8'h30, 8'hFC, 8'hE0, 8'h04};
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         apply(1'b0, ins[k], a[k], b[k],
               mk(res[k], res[k] == 8'h00, res[k], 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
         e = sb.pop_front();
         checks++;
         if (alu_out !== e.alu) begin
            errors++; $display("FAIL alu_%0d_out: got %h want %h", k, alu_out, e.alu);
         end
         checks++;
         if (zero !== e.z) begin
            errors++; $display("FAIL alu_%0d_zero: got %0b want %0b", k, zero, e.z);
         end
         checks++;
         if (wb_data !== e.wb || reg_write !== e.rw || reg_waddr !== e.wa) begin
            errors++;
            $display("FAIL alu_%0d_wb: got wb=%h rw=%0b wa=%0b want wb=%h rw=%0b wa=%0b",
                     k, wb_data, reg_write, reg_waddr, e.wb, e.rw, e.wa);
         end
      end
   endtask

   task automatic test_sw_lw();
      @(negedge clk);
      apply(1'b0, 8'h6A, 8'h10, 8'h00, mk(8'h12, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      checks++;
      if (mem_rdata !== e.mrd || alu_out !== e.alu) begin
         errors++; $display("FAIL lw_pre_write: got rd=%h addr=%h want rd=%h addr=%h",
                            mem_rdata, alu_out, e.mrd, e.alu);
      end
      apply(1'b0, 8'h8A, 8'h10, 8'h7E, mk(8'h12, 1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      checks++;
      if (mem_rdata !== e.mrd || reg_write !== e.rw) begin
         errors++; $display("FAIL sw_same_cycle: got rd=%h rw=%0b want rd=%h rw=%0b",
                            mem_rdata, reg_write, e.mrd, e.rw);
      end
      @(negedge clk);
      apply(1'b0, 8'h6A, 8'h10, 8'h00, mk(8'h12, 1'b0, 8'h7E, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      checks++;
      if (mem_rdata !== e.mrd) begin errors++; $display("FAIL lw_after_sw_rd: got %h want %h", mem_rdata, e.mrd); end
      checks++;
      if (wb_data !== e.wb) begin errors++; $display("FAIL lw_after_sw_wb: got %h want %h", wb_data, e.wb); end
      checks++;
      if (reg_waddr !== e.wa) begin errors++; $display("FAIL lw_after_sw_wa: got %0b want %0b", reg_waddr, e.wa); end
   endtask

   task automatic test_branch();
      @(negedge clk);
      apply(1'b0, 8'hA8, 8'h09, 8'h09, mk(8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      e = sb.pop_front();
      checks++;
      if (branch_taken !== e.bt || reg_write !== e.rw) begin
         errors++; $display("FAIL beq_equal: got bt=%0b rw=%0b want bt=%0b rw=%0b",
                            branch_taken, reg_write, e.bt, e.rw);
      end
      @(negedge clk);
      apply(1'b0, 8'hA8, 8'h09, 8'h08, mk(8'h01, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      checks++;
      if (branch_taken !== e.bt) begin
         errors++; $display("FAIL beq_unequal: got %0b want %0b", branch_taken, e.bt);
      end
   endtask

   task automatic test_jump();
      @(negedge clk);
      apply(1'b0, 8'hE0, 8'h10, 8'h02, mk(8'h12, 1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      e = sb.pop_front();
      checks++;
      if (jump !== e.j || reg_write !== e.rw) begin
         errors++; $display("FAIL j_decode: got j=%0b rw=%0b want j=%0b rw=%0b",
                            jump, reg_write, e.j, e.rw);
      end
      @(negedge clk);
      apply(1'b0, 8'h6A, 8'h10, 8'h00, mk(8'h12, 1'b0, 8'h7E, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      checks++;
      if (mem_rdata !== e.mrd) begin
         errors++; $display("FAIL j_no_mem_write: got %h want %h", mem_rdata, e.mrd);
      end
   endtask

   task automatic test_sw_during_rst();
      @(negedge clk);
      apply(1'b1, 8'hD5, 8'h00, 8'h00, mk(8'h05, 1'b0, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
      e = sb.pop_front();
      checks++;
      if (reg_write !== e.rw) begin
         errors++; $display("FAIL rst_forces_rw: got %0b want %0b", reg_write, e.rw);
      end
      apply(1'b1, 8'h8A, 8'h10, 8'h55, mk(8'h12, 1'b0, 8'h12, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      void'(sb.pop_front());
      @(negedge clk);
      apply(1'b0, 8'h6A, 8'h10, 8'h00, mk(8'h12, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      e = sb.pop_front();
      checks++;
      if (mem_rdata !== e.mrd || wb_data !== e.wb) begin
         errors++; $display("FAIL sw_with_rst_lost: got rd=%h wb=%h want rd=%h wb=%h",
                            mem_rdata, wb_data, e.mrd, e.wb);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; instr = 8'h00; rd_data1 = 8'h00; rd_data2 = 8'h00;
      test_reset();
      test_li();
      test_alu_ops();
      test_sw_lw();
      test_branch();
      test_jump();
      test_sw_during_rst();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
